// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MIPS memory-access / write-back stage.
package mem_wb_stage_pkg;

  localparam int unsigned DATA_W              = 32;
  localparam int unsigned REG_W               = 5;
  localparam int unsigned DEFAULT_MEM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WB   = 2'd2
  } state_e;

  // Load in flight: full ALU result (address and MemtoReg=0 data) plus data select.
  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic              mem_to_reg;
  } load_req_t;

  // Word-index width for a memory of the given depth.
  function automatic int unsigned addr_idx_w(input int unsigned words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
module data_memory
  import mem_wb_stage_pkg::*;
#(
  parameter  int unsigned WORDS = 256,
  localparam int unsigned IDX_W = addr_idx_w(WORDS)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: word load/store against local memory,
// then a one-cycle write-back pulse toward the register file.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] B,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] WriteData,
  output logic              wb_regwrite,
  output logic              err
);

  localparam int unsigned IDX_W = addr_idx_w(MEM_WORDS);
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  load_req_t         ld_q, ld_d;
  logic              in_ready_d;
  logic              wb_valid_d;
  logic              err_d;
  logic              wb_regwrite_d;
  logic [REG_W-1:0]  wb_reg_d;
  logic [DATA_W-1:0] write_data_d;

  logic              accept;
  logic              is_illegal;
  logic              is_store;
  logic              is_load;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata_c;

  // Classification of the instruction presented at the accepting edge.
  assign accept     = in_valid && in_ready;
  assign is_illegal = (MemRead && MemWrite) ||
                      ((MemRead || MemWrite) && (ALUOut[1:0] != 2'b00));
  assign is_store   = MemWrite && !is_illegal;
  assign is_load    = MemRead && !is_illegal;
  // Reset gating keeps memory untouched while the stage is held in reset.
  assign mem_we     = accept && is_store && RESET_N;

  data_memory #(.WORDS(MEM_WORDS)) u_data_memory (
    .CLK     (CLK),
    .we      (mem_we),
    .waddr   (ALUOut[IDX_W+1:2]),
    .wdata   (B),
    .raddr   (ld_q.alu_out[IDX_W+1:2]),
    .rdata_c (mem_rdata_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_d          = ld_q;
    err_d         = 1'b0;
    wb_reg_d      = wb_reg;
    wb_regwrite_d = wb_regwrite;
    write_data_d  = WriteData;

    case (state_q)
      LOAD: begin
        if (cnt_q == '0) begin
          write_data_d = ld_q.mem_to_reg ? mem_rdata_c : ld_q.alu_out;
          state_d      = WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (accept) begin
          if (is_illegal) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else if (is_store) begin
            state_d = IDLE;
          end else if (is_load) begin
            state_d         = LOAD;
            cnt_d           = CNT_W'(MEM_LATENCY - 1);
            ld_d.alu_out    = ALUOut;
            ld_d.mem_to_reg = MemtoReg;
            wb_reg_d        = WriteReg;
            wb_regwrite_d   = RegWrite;
          end else begin
            state_d       = WB;
            write_data_d  = ALUOut;
            wb_reg_d      = WriteReg;
            wb_regwrite_d = RegWrite;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    wb_valid_d = (state_d == WB);
    in_ready_d = (state_d != LOAD);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ld_q        <= '0;
      in_ready    <= 1'b1;
      wb_valid    <= 1'b0;
      wb_reg      <= '0;
      WriteData   <= '0;
      wb_regwrite <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      in_ready    <= in_ready_d;
      wb_valid    <= wb_valid_d;
      wb_reg      <= wb_reg_d;
      WriteData   <= write_data_d;
      wb_regwrite <= wb_regwrite_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, corner sequences,
// and a randomized run against a timeline-based reference model.
module tb_mem_wb_stage;

  localparam int unsigned MEM_WORDS   = 256;
  localparam int unsigned MEM_LATENCY = 2;
  localparam int          NV          = 12;
  localparam int          NRAND       = 400;
  localparam int          NT          = NRAND + MEM_LATENCY + 6;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUOut;
  logic [31:0] B;
  logic [4:0]  WriteReg;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] WriteData;
  logic        wb_regwrite;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.MEM_WORDS(MEM_WORDS), .MEM_LATENCY(MEM_LATENCY)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUOut      (ALUOut),
    .B           (B),
    .WriteReg    (WriteReg),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .WriteData   (WriteData),
    .wb_regwrite (wb_regwrite),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        mr, mw, m2r, rw;
    logic [31:0] alu, b;
    logic [4:0]  wreg;
    logic [3:0]  lat;
    logic        exp_err, exp_wb;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        exp_rw;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic mr, mw, m2r, rw, input logic [31:0] alu, b,
                              input logic [4:0] wreg, input logic [3:0] lat,
                              input logic ee, ew, input logic [4:0] er,
                              input logic [31:0] ed, input logic erw);
    vec_t v;
    v.mr = mr; v.mw = mw; v.m2r = m2r; v.rw = rw;
    v.alu = alu; v.b = b; v.wreg = wreg; v.lat = lat;
    v.exp_err = ee; v.exp_wb = ew; v.exp_reg = er; v.exp_data = ed; v.exp_rw = erw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] b,
                       input logic [4:0] wr, input logic mr, input logic mw,
                       input logic m2r, input logic rw);
    in_valid = v; ALUOut = alu; B = b; WriteReg = wr;
    MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: memory image plus a per-cycle timeline of expected outputs.
  logic [31:0] mmem    [MEM_WORDS];
  bit          written [MEM_WORDS];
  bit          e_ready [NT];
  bit          e_wb    [NT];
  bit          e_err   [NT];
  bit          e_known [NT];
  logic [4:0]  e_reg   [NT];
  logic [31:0] e_data  [NT];
  logic        e_rw    [NT];

  logic        rv, rmr, rmw, rm2r, rrw;
  logic [31:0] ralu, rb;
  logic [4:0]  rwr;
  int          op, e, w, idx;
  bit          illegal;
  localparam logic [3:0] LL = 4'(MEM_LATENCY + 1);

  initial begin
    vecs[0]  = mk(0,0,0,1, 32'h7,                     32'h0,        5'd2,  4'd1, 0,1, 5'd2,  32'h7,        1);
    vecs[1]  = mk(0,1,0,0, 32'h10,                    32'hDEADBEEF, 5'd0,  4'd1, 0,0, 5'd0,  32'h0,        0);
    vecs[2]  = mk(1,0,1,1, 32'h10,                    32'h0,        5'd9,  LL,   0,1, 5'd9,  32'hDEADBEEF, 1);
    vecs[3]  = mk(1,0,1,1, 32'h10 + 4 * MEM_WORDS,    32'h0,        5'd5,  LL,   0,1, 5'd5,  32'hDEADBEEF, 1);
    vecs[4]  = mk(1,0,1,1, 32'h12,                    32'h0,        5'd4,  4'd1, 1,0, 5'd0,  32'h0,        0);
    vecs[5]  = mk(1,1,1,1, 32'h10,                    32'h12345678, 5'd4,  4'd1, 1,0, 5'd0,  32'h0,        0);
    vecs[6]  = mk(1,0,1,1, 32'h10,                    32'h0,        5'd6,  LL,   0,1, 5'd6,  32'hDEADBEEF, 1);
    vecs[7]  = mk(1,0,0,1, 32'h10,                    32'h0,        5'd3,  LL,   0,1, 5'd3,  32'h10,       1);
    vecs[8]  = mk(0,0,0,0, 32'hFFFFFFFF,              32'h0,        5'd0,  4'd1, 0,1, 5'd0,  32'hFFFFFFFF, 0);
    vecs[9]  = mk(0,1,0,0, 32'h11,                    32'h55555555, 5'd0,  4'd1, 1,0, 5'd0,  32'h0,        0);
    vecs[10] = mk(0,1,0,0, 32'h14,                    32'hCAFEF00D, 5'd0,  4'd1, 0,0, 5'd0,  32'h0,        0);
    vecs[11] = mk(1,0,1,1, 32'h14,                    32'h0,        5'd31, LL,   0,1, 5'd31, 32'hCAFEF00D, 1);

    // Reset state.
    RESET_N = 1'b0;
    idle();
    repeat (3) step();
    chk("rst in_ready", in_ready, 1);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst err", err, 0);
    chk("rst WriteData", WriteData, 0);
    chk("rst wb_reg", wb_reg, 0);
    chk("rst wb_regwrite", wb_regwrite, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step();
    chk("post-rst in_ready", in_ready, 1);
    chk("post-rst wb_valid", wb_valid, 0);

    // Directed vector table; each row is accepted immediately (stage ready).
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].alu, vecs[i].b, vecs[i].wreg, vecs[i].mr, vecs[i].mw,
            vecs[i].m2r, vecs[i].rw);
      for (int c = 1; c <= int'(vecs[i].lat); c++) begin
        step();
        if (c == 1) begin
          idle();
          chk($sformatf("v%0d err", i), err, vecs[i].exp_err);
        end
        if (c < int'(vecs[i].lat)) begin
          chk($sformatf("v%0d c%0d wb_valid", i, c), wb_valid, 0);
          chk($sformatf("v%0d c%0d in_ready", i, c), in_ready, 0);
        end else begin
          chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].exp_wb);
          chk($sformatf("v%0d in_ready", i), in_ready, 1);
          if (vecs[i].exp_wb) begin
            chk($sformatf("v%0d wb_reg", i), wb_reg, vecs[i].exp_reg);
            chk($sformatf("v%0d WriteData", i), WriteData, vecs[i].exp_data);
            chk($sformatf("v%0d wb_regwrite", i), wb_regwrite, vecs[i].exp_rw);
          end
        end
      end
    end
    step();

    // Back-to-back R-type ops sustain one write-back per cycle.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 32'h0, 5'(i + 10), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk($sformatf("b2b%0d wb_valid", i), wb_valid, 1);
      chk($sformatf("b2b%0d WriteData", i), WriteData, 32'(i));
      chk($sformatf("b2b%0d wb_reg", i), wb_reg, 32'(i + 10));
    end
    idle();
    step();
    chk("b2b end wb_valid", wb_valid, 0);

    // Reset during the second LOAD cycle drops the load; memory survives.
    drive(1'b1, 32'h20, 32'hA5A50001, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h20, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    step();
    chk("midload in_ready", in_ready, 0);
    RESET_N = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst wb_valid", wb_valid, 0);
    chk("midrst WriteData", WriteData, 0);
    repeat (2) step();
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("postrst c%0d wb_valid", c), wb_valid, 0);
      chk($sformatf("postrst c%0d in_ready", c), in_ready, 1);
    end
    drive(1'b1, 32'h20, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    repeat (MEM_LATENCY) step();
    chk("preserved wb_valid", wb_valid, 1);
    chk("preserved WriteData", WriteData, 32'hA5A50001);
    chk("preserved wb_reg", wb_reg, 8);

    // Randomized run against the timeline model.
    for (int i = 0; i < int'(MEM_WORDS); i++) written[i] = 1'b0;
    for (int k = 0; k < NT; k++) begin
      e_ready[k] = 1'b1; e_wb[k] = 1'b0; e_err[k] = 1'b0; e_known[k] = 1'b0;
      e_reg[k] = '0; e_data[k] = '0; e_rw[k] = 1'b0;
    end
    idle();
    repeat (2) step();
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("rnd%0d in_ready", k), in_ready, e_ready[k]);
      chk($sformatf("rnd%0d wb_valid", k), wb_valid, e_wb[k]);
      chk($sformatf("rnd%0d err", k), err, e_err[k]);
      if (e_wb[k]) begin
        chk($sformatf("rnd%0d wb_reg", k), wb_reg, e_reg[k]);
        chk($sformatf("rnd%0d wb_regwrite", k), wb_regwrite, e_rw[k]);
        if (e_known[k]) chk($sformatf("rnd%0d WriteData", k), WriteData, e_data[k]);
      end
      if (k < NRAND) begin
        rv   = ($urandom_range(0, 3) != 0);
        op   = int'($urandom_range(0, 9));
        rmr  = (op >= 4 && op <= 6) || op == 9;
        rmw  = (op >= 7);
        rm2r = ($urandom_range(0, 4) != 0);
        rrw  = 1'($urandom_range(0, 1));
        rwr  = 5'($urandom_range(0, 31));
        rb   = $urandom;
        if (rmr || rmw)
          ralu = (32'($urandom_range(0, 3)) << 10) | (32'(64 + $urandom_range(0, 15)) << 2)
               | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        else
          ralu = $urandom;
      end else begin
        rv = 1'b0; rmr = 1'b0; rmw = 1'b0; rm2r = 1'b0; rrw = 1'b0;
        rwr = '0; rb = '0; ralu = '0;
      end
      drive(rv, ralu, rb, rwr, rmr, rmw, rm2r, rrw);
      if (rv && e_ready[k]) begin
        e       = k + 1;
        idx     = int'((ralu >> 2) % MEM_WORDS);
        illegal = (rmr && rmw) || ((rmr || rmw) && (ralu % 4 != 0));
        if (illegal) begin
          e_err[e] = 1'b1;
        end else if (rmw) begin
          mmem[idx]    = rb;
          written[idx] = 1'b1;
        end else if (rmr) begin
          for (int j = 0; j < int'(MEM_LATENCY); j++) e_ready[e + j] = 1'b0;
          w = e + int'(MEM_LATENCY);
          e_wb[w] = 1'b1; e_reg[w] = rwr; e_rw[w] = rrw;
          if (rm2r) begin
            e_known[w] = written[idx];
            e_data[w]  = mmem[idx];
          end else begin
            e_known[w] = 1'b1;
            e_data[w]  = ralu;
          end
        end else begin
          e_wb[e] = 1'b1; e_reg[e] = rwr; e_rw[e] = rrw;
          e_known[e] = 1'b1; e_data[e] = ralu;
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage sitting directly downstream of the MIPS ALU. It accepts one executed instruction per handshake: the ALU result, the store operand (register-file B output), the destination register and the memory/write-back control bits. It then performs the word load or store against a local data memory and emits a one-cycle write-back pulse (register index plus data) toward the register file write port.

## Interface
Parameters:
- MEM_WORDS, 256: data-memory depth in 32-bit words; power of two.
- MEM_LATENCY, 2: cycles a load spends in LOAD state; must be ≥1.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready at a rising edge.
- ALUOut  in  32  ALU result; byte address for loads and stores.
- B  in  32  store data.
- WriteReg  in  5  destination register.
- MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits from CONTROL.
- wb_valid  out  1  one-cycle write-back strobe.
- wb_reg  out  5  register to write.
- WriteData  out  32  data to write.
- wb_regwrite  out  1  registered RegWrite of the retiring instruction.
- err  out  1  one-cycle pulse on an illegal memory access.

## Operation
- FSM states: IDLE, LOAD, WB.
- in_ready = (state==IDLE || state==WB).
- Accept classification, evaluated on captured inputs:
  - Illegal: MemRead && MemWrite, or (MemRead || MemWrite) with ALUOut[1:0]≠0. Next state IDLE. err=1 for the next cycle. No memory write, no wb_valid.
  - Store: MemWrite only. Memory word written at the accepting edge. Next state IDLE. No wb_valid.
  - Load: MemRead only. Next state LOAD; latency counter loaded with MEM_LATENCY-1.
  - Other (R-type, addi): next state WB. WriteData = ALUOut.
- LOAD: counter decrements each cycle. At 0, WriteData captures the memory word and the FSM goes to WB. If MemtoReg=0 on a load, WriteData = ALUOut instead.
- WB: wb_valid=1 for exactly one cycle. wb_reg and wb_regwrite come from the captured WriteReg and RegWrite. If a new accept occurs in WB, classify it as above; otherwise go to IDLE.
- Address index = ALUOut[log2(MEM_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo MEM_WORDS×4.
- Register 0 is not special-cased; it is forwarded as given.
- Inputs are sampled only at the accepting edge and ignored at all other times.

## Timing
- Reset (async assert, sync release):
  - Outputs: state=IDLE, in_ready=1, wb_valid=0, wb_reg=0, WriteData=0, wb_regwrite=0, err=0.
  - Memory contents are not reset.
- Non-memory op accepted at edge t: wb_valid high in cycle t+1. Back-to-back accepts sustain one write-back per cycle.
- Load accepted at t:
  - LOAD occupies cycles t+1..t+MEM_LATENCY with in_ready=0.
  - wb_valid high in cycle t+MEM_LATENCY+1.
- Store accepted at t: memory updated at edge t. A load accepted at t+1 to the same address returns the new data.
- Illegal op accepted at t: err high in cycle t+1 only.
- Reset asserted during LOAD or WB: the in-flight instruction is dropped, no wb_valid follows, and memory is unchanged.
- No backpressure from the register file: wb_valid is never stalled.

## Structure
- Shared package holds:
  - state enum {IDLE, LOAD, WB};
  - DATA_W=32;
  - default MEM_LATENCY;
  - the address-index width function.
- One sub-module: data_memory. It has a synchronous write port and a combinational word read, indexed by word address, with depth MEM_WORDS.
- FSM, latency counter and output registers live in mem_wb_stage.

## Test plan
- Reset: hold RESET_N=0 mid-operation, then release. Required: in_ready=1, wb_valid=0, err=0, WriteData=0.
- R-type: ALUOut=0x7, WriteReg=2, RegWrite=1, MemtoReg=0, accepted at t. Required: wb_valid=1 at t+1, wb_reg=2, WriteData=0x7, wb_regwrite=1.
- Store/load (MEM_LATENCY=2):
  - Stimulus: sw ALUOut=0x10, B=0xDEADBEEF; next cycle lw ALUOut=0x10, WriteReg=9, MemtoReg=1.
  - Required: in_ready=0 for two cycles, then wb_valid with wb_reg=9, WriteData=0xDEADBEEF.
  - Then lw at ALUOut=0x10+4×MEM_WORDS returns the same word (wrap).
- Illegal access: lw at ALUOut=0x12, and separately MemRead=MemWrite=1. Required: err pulse at t+1, no wb_valid, memory at 0x10 unchanged.
- Reset mid-load: drop RESET_N during the second LOAD cycle. Required: wb_valid never asserts; after release in_ready=1 and memory contents are preserved.
- Back-to-back: three R-type ops with ALUOut=1,2,3 on consecutive cycles. Required: wb_valid high three consecutive cycles with WriteData=1,2,3.
